// File: rtl/reg_file_sb.sv
`default_nettype none
// ============================================================================
// Module   : reg_file_sb
// Purpose  : Two-read/one-write register file with a per-register busy scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module reg_file_sb #(
    parameter int               WIDTH    = 16,
    parameter int               DEPTH    = 8,
    parameter logic [WIDTH-1:0] INIT     = '0,
    parameter bit               BYPASS   = 1'b1,
    parameter bit               ZERO_REG = 1'b0,
    localparam int              AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr1,
    input  logic [AW-1:0]    raddr2,
    output logic [WIDTH-1:0] rdata1,
    output logic [WIDTH-1:0] rdata2,
    input  logic             issue,
    input  logic [AW-1:0]    issue_addr,
    input  logic             flush,
    output logic             busy1,
    output logic             busy2,
    output logic             any_busy
);

    localparam logic [AW:0] c_depth = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [DEPTH-1:0] r_busy;
    logic [DEPTH-1:0] w_busy_nxt;
    logic             w_wr_ok;
    logic             w_iss_ok;
    logic [AW-1:0]    w_raddr [2];
    logic [WIDTH-1:0] w_rdata [2];
    logic             w_rbusy [2];

    // Addresses past DEPTH and, when hardwired, register 0 are inert everywhere.
    function automatic logic f_addr_ok(input logic [AW-1:0] a);
        return ({1'b0, a} < c_depth) && !(ZERO_REG && (a == '0));
    endfunction

    assign w_wr_ok  = we && f_addr_ok(waddr);
    assign w_iss_ok = issue && f_addr_ok(issue_addr);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= (ZERO_REG && (i == 0)) ? '0 : INIT;
            end
        end else if (w_wr_ok) begin
            r_mem[waddr] <= wdata;
        end
    end

    // Set beats clear on the same register; flush beats both.
    always_comb begin
        w_busy_nxt = r_busy;
        if (w_wr_ok) begin
            w_busy_nxt[waddr] = 1'b0;
        end
        if (w_iss_ok) begin
            w_busy_nxt[issue_addr] = 1'b1;
        end
        if (flush) begin
            w_busy_nxt = '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_busy <= '0;
        end else begin
            r_busy <= w_busy_nxt;
        end
    end

    assign w_raddr[0] = raddr1;
    assign w_raddr[1] = raddr2;

    always_comb begin
        for (int p = 0; p < 2; p++) begin
            w_rdata[p] = '0;
            w_rbusy[p] = 1'b0;
            if (f_addr_ok(w_raddr[p])) begin
                w_rdata[p] = r_mem[w_raddr[p]];
                w_rbusy[p] = r_busy[w_raddr[p]];
                if (BYPASS && w_wr_ok && (waddr == w_raddr[p])) begin
                    w_rdata[p] = wdata;
                    // A same-address reservation keeps the registered busy visible.
                    if (!(w_iss_ok && (issue_addr == waddr))) begin
                        w_rbusy[p] = 1'b0;
                    end
                end
            end
        end
    end

    assign rdata1   = w_rdata[0];
    assign rdata2   = w_rdata[1];
    assign busy1    = w_rbusy[0];
    assign busy2    = w_rbusy[1];
    assign any_busy = |r_busy;

endmodule
`default_nettype wire

// File: tb/tb_reg_file_sb.sv
`default_nettype none
// ============================================================================
// Module   : tb_reg_file_sb
// Purpose  : Scoreboard bench driving three reg_file_sb configurations in lockstep.
// Revision : 1.0 - initial release
// ============================================================================
module tb_reg_file_sb;

    localparam int RD1 = 0, RD2 = 1, B1 = 2, B2 = 3, AB = 4;
    localparam int DA = 0, DB = 1, DC = 2;

    logic        clk;
    logic        reset;
    logic        we;
    logic [2:0]  waddr;
    logic [15:0] wdata;
    logic [2:0]  raddr1;
    logic [2:0]  raddr2;
    logic        issue;
    logic [2:0]  issue_addr;
    logic        flush;

    logic [15:0] rd1 [3];
    logic [15:0] rd2 [3];
    logic        b1  [3];
    logic        b2  [3];
    logic        ab  [3];

    typedef struct {
        int          id;
        int          sig;
        logic [15:0] exp;
        string       name;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    event sample_ev;

    // A: bypass, B: no bypass, C: zero register with non-power-of-two depth
    reg_file_sb #(.WIDTH(16), .DEPTH(8), .INIT(16'h00AA), .BYPASS(1'b1), .ZERO_REG(1'b0)) u_a (
        .clk(clk), .reset(reset), .we(we), .waddr(waddr), .wdata(wdata),
        .raddr1(raddr1), .raddr2(raddr2), .rdata1(rd1[0]), .rdata2(rd2[0]),
        .issue(issue), .issue_addr(issue_addr), .flush(flush),
        .busy1(b1[0]), .busy2(b2[0]), .any_busy(ab[0]));

    reg_file_sb #(.WIDTH(16), .DEPTH(8), .INIT(16'h00AA), .BYPASS(1'b0), .ZERO_REG(1'b0)) u_b (
        .clk(clk), .reset(reset), .we(we), .waddr(waddr), .wdata(wdata),
        .raddr1(raddr1), .raddr2(raddr2), .rdata1(rd1[1]), .rdata2(rd2[1]),
        .issue(issue), .issue_addr(issue_addr), .flush(flush),
        .busy1(b1[1]), .busy2(b2[1]), .any_busy(ab[1]));

    reg_file_sb #(.WIDTH(16), .DEPTH(6), .INIT(16'h00AA), .BYPASS(1'b1), .ZERO_REG(1'b1)) u_c (
        .clk(clk), .reset(reset), .we(we), .waddr(waddr), .wdata(wdata),
        .raddr1(raddr1), .raddr2(raddr2), .rdata1(rd1[2]), .rdata2(rd2[2]),
        .issue(issue), .issue_addr(issue_addr), .flush(flush),
        .busy1(b1[2]), .busy2(b2[2]), .any_busy(ab[2]));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [15:0] get_act(input int id, input int sig);
        case (sig)
            RD1:     return rd1[id];
            RD2:     return rd2[id];
            B1:      return {15'd0, b1[id]};
            B2:      return {15'd0, b2[id]};
            default: return {15'd0, ab[id]};
        endcase
    endfunction

    // Monitor: drains every queued expectation when a sample point is signalled.
    initial begin
        forever begin
            @(sample_ev);
            while (q.size() > 0) begin
                exp_t e;
                logic [15:0] act;
                e   = q.pop_front();
                act = get_act(e.id, e.sig);
                n_checks++;
                if (act === e.exp) begin
                    n_pass++;
                end else begin
                    $display("FAIL %s dut%0d: got %h expected %h", e.name, e.id, act, e.exp);
                end
            end
        end
    end

    task automatic chk(input int id, input int sig, input logic [15:0] e, input string nm);
        q.push_back('{id, sig, e, nm});
    endtask

    task automatic sample();
        -> sample_ev;
        #1;
        if (q.size() != 0) begin
            $display("FAIL monitor_timeout: got %0d pending expected 0", q.size());
            n_checks += q.size();
            q.delete();
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        we = 1'b0; issue = 1'b0; flush = 1'b0;
    endtask

    initial begin
        reset = 1'b1; we = 1'b0; waddr = '0; wdata = '0; raddr1 = 3'd3; raddr2 = 3'd7;
        issue = 1'b0; issue_addr = '0; flush = 1'b0;
        #1 reset = 1'b0;
        #1;
        chk(DA, RD1, 16'h00AA, "reset_rd1"); chk(DA, RD2, 16'h00AA, "reset_rd2");
        chk(DA, B1, 16'h0, "reset_busy1"); chk(DA, B2, 16'h0, "reset_busy2");
        chk(DA, AB, 16'h0, "reset_any_busy");
        chk(DC, RD1, 16'h00AA, "reset_c_rd1"); chk(DC, RD2, 16'h0000, "oor_read_rd2");
        sample();

        // Activity during reset must be ignored
        we = 1'b1; waddr = 3'd3; wdata = 16'h5555; issue = 1'b1; issue_addr = 3'd2;
        tick();
        idle();
        #1;
        chk(DA, RD1, 16'h00AA, "write_in_reset"); chk(DA, AB, 16'h0, "issue_in_reset");
        sample();
        reset = 1'b1;
        tick();

        // Same-cycle write-to-read forwarding
        we = 1'b1; waddr = 3'd3; wdata = 16'h1234; raddr1 = 3'd3;
        #1;
        chk(DA, RD1, 16'h1234, "bypass_rd1"); chk(DB, RD1, 16'h00AA, "nobypass_old");
        chk(DC, RD1, 16'h1234, "bypass_c_rd1");
        sample();
        tick();
        idle();
        #1;
        chk(DB, RD1, 16'h1234, "nobypass_new"); chk(DA, RD1, 16'h1234, "bypass_after");
        sample();

        // Reservation then write-back clears busy
        issue = 1'b1; issue_addr = 3'd5;
        #1;
        chk(DA, AB, 16'h0, "any_busy_registered");
        sample();
        tick();
        idle(); raddr2 = 3'd5;
        #1;
        chk(DA, B2, 16'h1, "issue_busy2"); chk(DA, AB, 16'h1, "issue_any_busy");
        chk(DB, B2, 16'h1, "issue_b_busy2"); chk(DC, B2, 16'h1, "issue_c_busy2");
        sample();
        we = 1'b1; waddr = 3'd5; wdata = 16'h0BEE;
        #1;
        chk(DA, B2, 16'h0, "bypass_busy2"); chk(DA, RD2, 16'h0BEE, "bypass_rd2");
        chk(DB, B2, 16'h1, "nobypass_busy2"); chk(DB, RD2, 16'h00AA, "nobypass_rd2");
        chk(DA, AB, 16'h1, "any_busy_pre_edge");
        sample();
        tick();
        idle();
        #1;
        chk(DA, B2, 16'h0, "wb_busy2"); chk(DA, AB, 16'h0, "wb_any_busy");
        chk(DB, AB, 16'h0, "wb_b_any_busy"); chk(DB, RD2, 16'h0BEE, "wb_b_rd2");
        sample();

        // Issue and write to the same register: set wins
        issue = 1'b1; issue_addr = 3'd2; we = 1'b1; waddr = 3'd2; wdata = 16'h2222; raddr1 = 3'd2;
        #1;
        chk(DA, RD1, 16'h2222, "same_addr_bypass"); chk(DA, B1, 16'h0, "same_addr_pre_busy");
        sample();
        tick();
        idle();
        #1;
        chk(DA, RD1, 16'h2222, "same_addr_rd1"); chk(DA, B1, 16'h1, "same_addr_busy1");
        chk(DB, B1, 16'h1, "same_addr_b_busy1");
        sample();

        // Issue and write to different registers
        issue = 1'b1; issue_addr = 3'd4; we = 1'b1; waddr = 3'd2; wdata = 16'h3333;
        tick();
        idle(); raddr1 = 3'd2; raddr2 = 3'd4;
        #1;
        chk(DA, B1, 16'h0, "diff_clear"); chk(DA, B2, 16'h1, "diff_set");
        chk(DA, RD1, 16'h3333, "diff_rd1");
        sample();

        // Register 0 hardwired in C
        we = 1'b1; waddr = 3'd0; wdata = 16'hFFFF; issue = 1'b1; issue_addr = 3'd0; raddr1 = 3'd0;
        #1;
        chk(DC, RD1, 16'h0000, "zero_no_bypass"); chk(DA, RD1, 16'hFFFF, "zero_a_bypass");
        sample();
        tick();
        idle();
        #1;
        chk(DC, RD1, 16'h0000, "zero_rd1"); chk(DC, B1, 16'h0, "zero_busy1");
        chk(DA, RD1, 16'hFFFF, "a_reg0"); chk(DA, B1, 16'h1, "a_reg0_busy");
        sample();

        // Out-of-range write/issue on C
        we = 1'b1; waddr = 3'd6; wdata = 16'h6666; issue = 1'b1; issue_addr = 3'd7;
        tick();
        idle(); raddr1 = 3'd6; raddr2 = 3'd7;
        #1;
        chk(DC, RD1, 16'h0000, "oor_write"); chk(DC, B2, 16'h0, "oor_issue");
        chk(DA, RD1, 16'h6666, "a_reg6"); chk(DA, B2, 16'h1, "a_busy7");
        sample();

        // Build busy {1,4,6}, then flush against a concurrent issue
        flush = 1'b1;
        tick();
        idle(); issue = 1'b1; issue_addr = 3'd1;
        tick();
        issue_addr = 3'd4;
        tick();
        issue_addr = 3'd6;
        tick();
        idle(); raddr1 = 3'd1; raddr2 = 3'd6;
        #1;
        chk(DA, B1, 16'h1, "pre_flush_b1"); chk(DA, B2, 16'h1, "pre_flush_b6");
        chk(DA, AB, 16'h1, "pre_flush_any");
        sample();
        flush = 1'b1; issue = 1'b1; issue_addr = 3'd7; we = 1'b1; waddr = 3'd4; wdata = 16'h4444;
        tick();
        idle(); raddr1 = 3'd7; raddr2 = 3'd4;
        #1;
        chk(DA, B1, 16'h0, "flush_issue7"); chk(DA, B2, 16'h0, "flush_b4");
        chk(DA, AB, 16'h0, "flush_any"); chk(DA, RD2, 16'h4444, "flush_write");
        chk(DB, AB, 16'h0, "flush_b_any"); chk(DC, AB, 16'h0, "flush_c_any");
        sample();

        // Asynchronous reset mid-stream
        issue = 1'b1; issue_addr = 3'd3;
        tick();
        idle(); raddr1 = 3'd3; raddr2 = 3'd4;
        #1;
        chk(DA, AB, 16'h1, "pre_reset_any");
        sample();
        #1 reset = 1'b0;
        #1;
        chk(DA, RD1, 16'h00AA, "mid_reset_rd1"); chk(DA, RD2, 16'h00AA, "mid_reset_rd2");
        chk(DA, AB, 16'h0, "mid_reset_any"); chk(DC, RD1, 16'h00AA, "mid_reset_c_rd1");
        sample();
        reset = 1'b1;
        we = 1'b1; waddr = 3'd1; wdata = 16'hABCD; raddr1 = 3'd1;
        tick();
        idle();
        #1;
        chk(DB, RD1, 16'hABCD, "post_reset_write"); chk(DA, RD1, 16'hABCD, "post_reset_a");
        sample();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/reg_file_sb.md
REG_FILE_SB -- requirements
Module: reg_file_sb

Interface
REQ-001 SHALL have parameter WIDTH, default 16: data width of each register.
REQ-002 SHALL have parameter DEPTH, default 8: number of registers; AW = max(1, ceil(log2(DEPTH))) address bits.
REQ-003 SHALL have parameter INIT, default 0: WIDTH-bit reset value loaded into every register.
REQ-004 SHALL have parameter BYPASS, default 1: 1 = same-cycle write-to-read forwarding; 0 = none.
REQ-005 SHALL have parameter ZERO_REG, default 0: 1 = register 0 hardwired to zero.
REQ-006 SHALL use one clock; reset is asynchronous and active-low.
REQ-007 clk  input  1  rising-edge clock.
REQ-008 reset  input  1  asynchronous, active-low reset.
REQ-009 we  input  1  write enable.
REQ-010 waddr  input  AW  write address.
REQ-011 wdata  input  WIDTH  write data.
REQ-012 raddr1, raddr2  input  AW each  read addresses, ports 1 and 2.
REQ-013 rdata1, rdata2  output  WIDTH each  combinational read data.
REQ-014 issue  input  1  marks issue_addr as having a pending producer.
REQ-015 issue_addr  input  AW  register being reserved.
REQ-016 flush  input  1  synchronous clear of all busy bits.
REQ-017 busy1, busy2  output  1 each  pending-write status of raddr1 / raddr2.
REQ-018 any_busy  output  1  OR of all busy bits, registered state only.

Function
REQ-019 SHALL write wdata into reg[waddr] on the rising clk edge when we=1.
REQ-020 SHALL leave all registers unchanged when we=0.
REQ-021 Reads: rdataN = reg[raddrN], combinational, no latency.
REQ-022 BYPASS=1, we=1 and waddr==raddrN: SHALL drive rdataN = wdata in the same cycle.
REQ-023 BYPASS=0: SHALL return the pre-edge register value; the new value is visible the cycle after the write.
REQ-024 ZERO_REG=1: reads of address 0 SHALL return 0, writes to 0 SHALL be ignored, issue to 0 SHALL be ignored; no bypass on address 0.
REQ-025 Address >= DEPTH (non-power-of-two DEPTH): read SHALL return 0 with busy=0; write and issue SHALL be ignored.
REQ-026 Scoreboard: one busy bit per register.
REQ-027 issue=1 SHALL set busy[issue_addr] at the clock edge.
REQ-028 we=1 SHALL clear busy[waddr] at the clock edge.
REQ-029 issue and we to the same address in the same cycle: set SHALL win, busy=1 after the edge.
REQ-030 issue and we to different addresses in the same cycle: both updates SHALL take effect.
REQ-031 flush=1 SHALL clear all busy bits at the edge, overriding issue and we-clear in that cycle; register data SHALL still be written if we=1.
REQ-032 busyN = busy[raddrN], except BYPASS=1 with we=1, waddr==raddrN and no same-address issue: busyN SHALL read 0.
REQ-033 Read port 1 and read port 2 SHALL be fully independent; both MAY address the same register.

Reset
REQ-034 reset=0 SHALL immediately, without waiting for clk, set every register to INIT (register 0 reads 0 when ZERO_REG=1) and clear all busy bits.
REQ-035 While reset=0, writes, issue and flush SHALL be ignored.
REQ-036 After reset deasserts, the first clk edge SHALL accept normal operation.
REQ-037 Reset asserted mid-operation SHALL discard all pending reservations.

Verification
REQ-038 Bench SHALL cover: reset with INIT=16'h00AA -> all rdata=00AA, busy1=busy2=any_busy=0 before any clk edge.
REQ-039 Bench SHALL cover: BYPASS=1, we=1, waddr=3, wdata=1234, raddr1=3 in the same cycle -> rdata1=1234 combinationally; BYPASS=0 -> old value, then 1234 the next cycle.
REQ-040 Bench SHALL cover: issue addr 5; next cycle raddr2=5 -> busy2=1, any_busy=1; write addr 5 -> busy2=0 and any_busy=0 after the edge.
REQ-041 Bench SHALL cover: issue=1 and we=1 both addr 2 in the same cycle -> reg2=wdata, busy[2]=1 after the edge.
REQ-042 Bench SHALL cover: ZERO_REG=1, write FFFF to addr 0 -> rdata=0000; issue addr 0 -> busy stays 0.
REQ-043 Bench SHALL cover: busy bits 1, 4, 6 set, then flush=1 with issue addr 7 -> all busy=0; then assert reset mid-stream -> registers=INIT asynchronously.
